// File: rtl/spatz_offload_sequencer.sv
// Offload sequencer for Spatz: in-order instruction queue with head classification
// into VFU / VLSU / CSR issue paths, CSR drain serialisation and illegal-op reject.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | head issues to VFU/VLSU, illegal heads are rejected
// DRAIN | CSR at head; waiting for outstanding==0, then issue to CSR
module spatz_offload_sequencer #(
    parameter int unsigned QueueDepth     = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned IdWidth        = 5
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [31:0]                           req_instr_i,
    input  logic [IdWidth-1:0]                    req_id_i,
    output logic                                  vfu_valid_o,
    input  logic                                  vfu_ready_i,
    output logic                                  vlsu_valid_o,
    input  logic                                  vlsu_ready_i,
    output logic                                  csr_valid_o,
    input  logic                                  csr_ready_i,
    output logic [31:0]                           issue_instr_o,
    output logic [IdWidth-1:0]                    issue_id_o,
    input  logic                                  retire_vfu_i,
    input  logic                                  retire_vlsu_i,
    output logic                                  rej_valid_o,
    output logic [IdWidth-1:0]                    rej_id_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  busy_o
);

    localparam int unsigned PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
    localparam int unsigned CntW = $clog2(QueueDepth + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    localparam logic [6:0] OpVec     = 7'b1010111;
    localparam logic [6:0] OpLoadFp  = 7'b0000111;
    localparam logic [6:0] OpStoreFp = 7'b0100111;
    localparam logic [6:0] OpSystem  = 7'b1110011;

    typedef enum logic [1:0] {ClsVfu, ClsVlsu, ClsCsr, ClsIllegal} cls_e;
    typedef enum logic {StRun, StDrain} state_e;

    logic [31:0]        instr_q [QueueDepth];
    logic [31:0]        instr_d [QueueDepth];
    logic [IdWidth-1:0] id_q    [QueueDepth];
    logic [IdWidth-1:0] id_d    [QueueDepth];
    logic [PtrW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [OutW-1:0]    out_q, out_d;
    state_e             state_q, state_d;

    logic               empty, full, push, pop, below_limit, issue_hs;
    logic               vfu_v, vlsu_v, csr_v, rej_v;
    logic [31:0]        head_instr;
    logic [IdWidth-1:0] head_id;
    cls_e               cls;
    logic [OutW:0]      out_sum, out_dec;

    assign empty       = (cnt_q == '0);
    assign full        = (cnt_q == CntW'(QueueDepth));
    assign head_instr  = instr_q[rptr_q];
    assign head_id     = id_q[rptr_q];
    assign below_limit = (out_q < OutW'(MaxOutstanding));

    // Ready only depends on fullness; a pop in the same cycle does not free a slot early.
    assign req_ready_o = !full && !rst_i;
    assign push        = req_valid_i && req_ready_o;

    // Decode the major opcode of the head entry.
    always_comb begin
        cls = ClsIllegal;
        case (head_instr[6:0])
            OpVec:               cls = ClsVfu;
            OpLoadFp, OpStoreFp: cls = ClsVlsu;
            OpSystem:            cls = ClsCsr;
            default:             cls = ClsIllegal;
        endcase
    end

    // Issue / reject decisions and FSM next state; valids depend only on registered state.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        vfu_v   = 1'b0;
        vlsu_v  = 1'b0;
        csr_v   = 1'b0;
        rej_v   = 1'b0;
        if (!empty) begin
            case (state_q)
                StRun: begin
                    case (cls)
                        ClsVfu: begin
                            vfu_v = below_limit;
                            pop   = vfu_v && vfu_ready_i;
                        end
                        ClsVlsu: begin
                            vlsu_v = below_limit;
                            pop    = vlsu_v && vlsu_ready_i;
                        end
                        ClsCsr:  state_d = StDrain;
                        default: begin
                            rej_v = 1'b1;
                            pop   = 1'b1;
                        end
                    endcase
                end
                StDrain: begin
                    csr_v = (out_q == '0);
                    if (csr_v && csr_ready_i) begin
                        pop     = 1'b1;
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    assign issue_hs = (vfu_v && vfu_ready_i) || (vlsu_v && vlsu_ready_i);

    // Queue storage and pointer bookkeeping; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        instr_d = instr_q;
        id_d    = id_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) begin
            instr_d[wptr_q] = req_instr_i;
            id_d[wptr_q]    = req_id_i;
            wptr_d          = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end

    // Outstanding counter: issue and retires net out; underflow clamps at zero.
    always_comb begin
        out_sum = {1'b0, out_q} + (OutW+1)'(issue_hs);
        out_dec = (OutW+1)'(retire_vfu_i) + (OutW+1)'(retire_vlsu_i);
        out_d   = (out_sum < out_dec) ? '0 : OutW'(out_sum - out_dec);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            state_q <= StRun;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            state_q <= state_d;
        end
    end

    // Payload storage needs no reset; the empty flag masks stale entries.
    always_ff @(posedge clk_i) begin
        instr_q <= instr_d;
        id_q    <= id_d;
    end

    // A retire with nothing outstanding is a downstream protocol violation.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (out_sum >= out_dec);
        end
    end

    assign vfu_valid_o   = vfu_v && !rst_i;
    assign vlsu_valid_o  = vlsu_v && !rst_i;
    assign csr_valid_o   = csr_v && !rst_i;
    assign rej_valid_o   = rej_v && !rst_i;
    assign rej_id_o      = rej_valid_o ? head_id : '0;
    assign issue_instr_o = (rst_i || empty) ? '0 : head_instr;
    assign issue_id_o    = (rst_i || empty) ? '0 : head_id;
    assign outstanding_o = rst_i ? '0 : out_q;
    assign busy_o        = !rst_i && (!empty || (out_q != '0));

endmodule

// File: tb/tb_spatz_offload_sequencer.sv
// Bench for spatz_offload_sequencer: opcode table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_spatz_offload_sequencer;

    localparam int QD = 4;
    localparam int MO = 8;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [31:0]   req_instr;
    logic [IW-1:0] req_id;
    logic          vfu_valid, vfu_ready, vlsu_valid, vlsu_ready, csr_valid, csr_ready;
    logic [31:0]   issue_instr;
    logic [IW-1:0] issue_id;
    logic          retire_vfu, retire_vlsu;
    logic          rej_valid;
    logic [IW-1:0] rej_id;
    logic [3:0]    outstanding;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spatz_offload_sequencer #(.QueueDepth(QD), .MaxOutstanding(MO), .IdWidth(IW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_instr_i(req_instr), .req_id_i(req_id),
        .vfu_valid_o(vfu_valid), .vfu_ready_i(vfu_ready),
        .vlsu_valid_o(vlsu_valid), .vlsu_ready_i(vlsu_ready),
        .csr_valid_o(csr_valid), .csr_ready_i(csr_ready),
        .issue_instr_o(issue_instr), .issue_id_o(issue_id),
        .retire_vfu_i(retire_vfu), .retire_vlsu_i(retire_vlsu),
        .rej_valid_o(rej_valid), .rej_id_o(rej_id),
        .outstanding_o(outstanding), .busy_o(busy)
    );

    typedef struct {
        logic [31:0]   instr;
        logic [IW-1:0] id;
        logic          vfu;
        logic          vlsu;
        logic          csr_next;
        logic          rej;
    } vec_t;

    typedef struct {
        logic [31:0]   instr;
        logic [IW-1:0] id;
    } entry_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_instr   = '0;
        req_id      = '0;
        vfu_ready   = 1'b0;
        vlsu_ready  = 1'b0;
        csr_ready   = 1'b0;
        retire_vfu  = 1'b0;
        retire_vlsu = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic all_ready();
        vfu_ready  = 1'b1;
        vlsu_ready = 1'b1;
        csr_ready  = 1'b1;
    endtask

    // 0 = VFU, 1 = VLSU, 2 = CSR, 3 = illegal
    function automatic int classify(input logic [31:0] instr);
        logic [6:0] op;
        op = instr[6:0];
        if (op == 7'h57) return 0;
        if (op == 7'h07 || op == 7'h27) return 1;
        if (op == 7'h73) return 2;
        return 3;
    endfunction

    vec_t   tbl [10];
    entry_t mq [$];

    initial begin
        int pushed, issues, got, retired;
        int mout;
        bit mdrain;

        tbl[0] = '{32'h0000_0057, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0007, 5'd2,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_0027, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_0073, 5'd4,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{32'h0000_0033, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{32'h0000_007F, 5'd6,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{32'hFFFF_FFD7, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'h0000_0047, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{32'h0000_0077, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{32'h1234_5053, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst_vfu_valid", 32'(vfu_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_outstanding", 32'(outstanding), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Opcode classification table.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            all_ready();
            req_valid = 1'b1;
            req_instr = tbl[i].instr;
            req_id    = tbl[i].id;
            cyc();
            req_valid = 1'b0;
            #1;
            chk($sformatf("tbl%0d_vfu", i),   32'(vfu_valid),  32'(tbl[i].vfu));
            chk($sformatf("tbl%0d_vlsu", i),  32'(vlsu_valid), 32'(tbl[i].vlsu));
            chk($sformatf("tbl%0d_csr0", i),  32'(csr_valid),  32'd0);
            chk($sformatf("tbl%0d_rej", i),   32'(rej_valid),  32'(tbl[i].rej));
            if (tbl[i].rej) chk($sformatf("tbl%0d_rej_id", i), 32'(rej_id), 32'(tbl[i].id));
            chk($sformatf("tbl%0d_instr", i), issue_instr, tbl[i].instr);
            chk($sformatf("tbl%0d_id", i),    32'(issue_id),   32'(tbl[i].id));
            cyc();
            chk($sformatf("tbl%0d_csr1", i),  32'(csr_valid),  32'(tbl[i].csr_next));
        end

        // Reset in the middle of a stalled VFU handshake.
        do_reset();
        req_valid = 1'b1;
        req_instr = 32'h57;
        for (int k = 0; k < 3; k++) begin
            req_id = 5'(k);
            cyc();
        end
        req_valid = 1'b0;
        #1;
        chk("mid_vfu_valid", 32'(vfu_valid), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_vfu_valid", 32'(vfu_valid), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_after_vfu_valid", 32'(vfu_valid), 32'd0);
        chk("mid_after_ready", 32'(req_ready), 32'd1);
        chk("mid_after_outstanding", 32'(outstanding), 32'd0);
        chk("mid_after_busy", 32'(busy), 32'd0);
        cyc();
        chk("mid_flushed_vfu_valid", 32'(vfu_valid), 32'd0);

        // Back-to-back VFU then VLSU, then a double retire.
        do_reset();
        all_ready();
        req_valid = 1'b1; req_instr = 32'h57; req_id = 5'd1;
        cyc();
        req_instr = 32'h07; req_id = 5'd2;
        #1;
        chk("b2b_vfu_valid", 32'(vfu_valid), 32'd1);
        chk("b2b_vfu_id", 32'(issue_id), 32'd1);
        chk("b2b_vlsu_idle", 32'(vlsu_valid), 32'd0);
        cyc();
        req_valid = 1'b0;
        #1;
        chk("b2b_vlsu_valid", 32'(vlsu_valid), 32'd1);
        chk("b2b_vlsu_id", 32'(issue_id), 32'd2);
        chk("b2b_out1", 32'(outstanding), 32'd1);
        cyc();
        chk("b2b_out2", 32'(outstanding), 32'd2);
        retire_vfu = 1'b1; retire_vlsu = 1'b1;
        cyc();
        retire_vfu = 1'b0; retire_vlsu = 1'b0;
        #1;
        chk("b2b_out0", 32'(outstanding), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd0);

        // CSR drains two outstanding vector ops and blocks the vector behind it.
        do_reset();
        vfu_ready = 1'b1; vlsu_ready = 1'b1;
        req_valid = 1'b1; req_instr = 32'h57; req_id = 5'd1;
        cyc();
        req_id = 5'd2;
        cyc();
        req_instr = 32'h73; req_id = 5'd3;
        cyc();
        req_instr = 32'h57; req_id = 5'd4;
        cyc();
        req_valid = 1'b0;
        #1;
        chk("csr_wait_valid", 32'(csr_valid), 32'd0);
        chk("csr_wait_vfu", 32'(vfu_valid), 32'd0);
        chk("csr_wait_out", 32'(outstanding), 32'd2);
        retire_vfu = 1'b1;
        cyc();
        retire_vfu = 1'b0;
        #1;
        chk("csr_out1", 32'(outstanding), 32'd1);
        chk("csr_out1_valid", 32'(csr_valid), 32'd0);
        cyc();
        chk("csr_out1_hold", 32'(csr_valid), 32'd0);
        retire_vfu = 1'b1;
        cyc();
        retire_vfu = 1'b0;
        #1;
        chk("csr_out0", 32'(outstanding), 32'd0);
        chk("csr_valid_up", 32'(csr_valid), 32'd1);
        chk("csr_issue_id", 32'(issue_id), 32'd3);
        chk("csr_vfu_blocked", 32'(vfu_valid), 32'd0);
        cyc();
        chk("csr_valid_held", 32'(csr_valid), 32'd1);
        chk("csr_vfu_blocked2", 32'(vfu_valid), 32'd0);
        csr_ready = 1'b1;
        cyc();
        csr_ready = 1'b0;
        #1;
        chk("csr_done_valid", 32'(csr_valid), 32'd0);
        chk("csr_next_vfu", 32'(vfu_valid), 32'd1);
        chk("csr_next_id", 32'(issue_id), 32'd4);

        // Illegal opcode rejected for one cycle; next entry follows immediately.
        do_reset();
        all_ready();
        req_valid = 1'b1; req_instr = 32'h33; req_id = 5'd5;
        cyc();
        req_instr = 32'h57; req_id = 5'd6;
        #1;
        chk("ill_rej", 32'(rej_valid), 32'd1);
        chk("ill_rej_id", 32'(rej_id), 32'd5);
        chk("ill_vfu0", 32'(vfu_valid), 32'd0);
        cyc();
        req_valid = 1'b0;
        #1;
        chk("ill_rej_off", 32'(rej_valid), 32'd0);
        chk("ill_next_vfu", 32'(vfu_valid), 32'd1);
        chk("ill_next_id", 32'(issue_id), 32'd6);

        // Outstanding limit: 8 issues, then exactly one more after a retire.
        do_reset();
        vfu_ready = 1'b1;
        pushed = 0; issues = 0;
        for (int c = 0; c < 30; c++) begin
            req_valid = (pushed < 10);
            req_instr = 32'h57;
            req_id    = 5'(pushed);
            #1;
            if (vfu_valid) issues++;
            if (req_valid && req_ready) pushed++;
            cyc();
        end
        req_valid = 1'b0;
        #1;
        chk("lim_issues", 32'(issues), 32'd8);
        chk("lim_vfu_valid", 32'(vfu_valid), 32'd0);
        chk("lim_out", 32'(outstanding), 32'd8);
        retire_vfu = 1'b1;
        cyc();
        retire_vfu = 1'b0;
        issues = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (vfu_valid) issues++;
            cyc();
        end
        chk("lim_one_more", 32'(issues), 32'd1);
        chk("lim_out_again", 32'(outstanding), 32'd8);

        // Queue full boundary, no same-cycle pop bypass.
        do_reset();
        req_valid = 1'b1; req_instr = 32'h57;
        for (int k = 0; k < 4; k++) begin
            req_id = 5'(k);
            #1;
            chk($sformatf("full_rdy%0d", k), 32'(req_ready), 32'd1);
            cyc();
        end
        chk("full_rdy_after4", 32'(req_ready), 32'd0);
        vfu_ready = 1'b1;
        #1;
        chk("full_no_bypass", 32'(req_ready), 32'd0);
        cyc();
        req_valid = 1'b0; vfu_ready = 1'b0;
        #1;
        chk("full_rdy_freed", 32'(req_ready), 32'd1);

        // Issue plus two retires at outstanding 3.
        do_reset();
        req_valid = 1'b1; req_instr = 32'h57;
        for (int k = 0; k < 4; k++) begin
            req_id = 5'(k);
            cyc();
        end
        req_valid = 1'b0;
        vfu_ready = 1'b1;
        cyc(); cyc(); cyc();
        chk("net_out3", 32'(outstanding), 32'd3);
        chk("net_vfu_valid", 32'(vfu_valid), 32'd1);
        retire_vfu = 1'b1; retire_vlsu = 1'b1;
        cyc();
        retire_vfu = 1'b0; retire_vlsu = 1'b0; vfu_ready = 1'b0;
        #1;
        chk("net_out2", 32'(outstanding), 32'd2);

        // Pointer wrap: 10 instructions in order with their ids.
        do_reset();
        all_ready();
        pushed = 0; got = 0; retired = 0;
        for (int c = 0; c < 40; c++) begin
            req_valid  = (pushed < 10);
            req_instr  = {25'(pushed + 100), 7'h57};
            req_id     = 5'(10 + pushed);
            retire_vfu = (got > retired);
            #1;
            if (vfu_valid) begin
                chk($sformatf("wrap_id%0d", got), 32'(issue_id), 32'(10 + got));
                chk($sformatf("wrap_instr%0d", got), issue_instr, {25'(got + 100), 7'h57});
                got++;
            end
            if (req_valid && req_ready) pushed++;
            if (retire_vfu) retired++;
            cyc();
        end
        retire_vfu = 1'b0; req_valid = 1'b0;
        chk("wrap_count", 32'(got), 32'd10);

        // Randomized traffic against the reference model.
        do_reset();
        mq.delete();
        mout = 0;
        mdrain = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int cl;
            bit e_vfu, e_vlsu, e_csr, e_rej, e_rdy, hs, pop;
            logic [6:0] op;
            rst = ($urandom_range(0, 199) == 0);
            req_valid = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = 7'h57;
                4:          op = 7'h07;
                5:          op = 7'h27;
                6:          op = 7'h73;
                7:          op = 7'h33;
                8:          op = 7'h13;
                default:    op = 7'($urandom);
            endcase
            req_instr  = {25'($urandom), op};
            req_id     = 5'($urandom);
            vfu_ready  = ($urandom_range(0, 3) != 0);
            vlsu_ready = ($urandom_range(0, 3) != 0);
            csr_ready  = ($urandom_range(0, 1) != 0);
            retire_vfu  = 1'b0;
            retire_vlsu = 1'b0;
            if (!rst) begin
                retire_vfu  = (mout >= 1) && ($urandom_range(0, 9) < 3);
                retire_vlsu = (mout >= 1 + int'(retire_vfu)) && ($urandom_range(0, 9) < 3);
            end
            #1;
            if (rst) begin
                chk("rnd_rst_vfu", 32'(vfu_valid), 32'd0);
                chk("rnd_rst_vlsu", 32'(vlsu_valid), 32'd0);
                chk("rnd_rst_csr", 32'(csr_valid), 32'd0);
                chk("rnd_rst_rej", 32'(rej_valid), 32'd0);
                chk("rnd_rst_busy", 32'(busy), 32'd0);
                chk("rnd_rst_instr", issue_instr, 32'd0);
                mq.delete();
                mout = 0;
                mdrain = 1'b0;
                cyc();
                continue;
            end
            e_rdy = (mq.size() < QD);
            e_vfu = 0; e_vlsu = 0; e_csr = 0; e_rej = 0;
            cl = 3;
            if (mq.size() > 0) begin
                cl = classify(mq[0].instr);
                if (mdrain)       e_csr  = (mout == 0);
                else if (cl == 0) e_vfu  = (mout < MO);
                else if (cl == 1) e_vlsu = (mout < MO);
                else if (cl == 3) e_rej  = 1;
            end
            chk("rnd_ready", 32'(req_ready), 32'(e_rdy));
            chk("rnd_vfu", 32'(vfu_valid), 32'(e_vfu));
            chk("rnd_vlsu", 32'(vlsu_valid), 32'(e_vlsu));
            chk("rnd_csr", 32'(csr_valid), 32'(e_csr));
            chk("rnd_rej", 32'(rej_valid), 32'(e_rej));
            chk("rnd_out", 32'(outstanding), 32'(mout));
            chk("rnd_busy", 32'(busy), 32'((mq.size() > 0) || (mout != 0)));
            if (mq.size() > 0) begin
                chk("rnd_instr", issue_instr, mq[0].instr);
                chk("rnd_id", 32'(issue_id), 32'(mq[0].id));
                if (e_rej) chk("rnd_rej_id", 32'(rej_id), 32'(mq[0].id));
            end
            hs  = (e_vfu && vfu_ready) || (e_vlsu && vlsu_ready);
            pop = hs || (e_csr && csr_ready) || e_rej;
            if (mq.size() > 0 && !mdrain && cl == 2) mdrain = 1'b1;
            else if (e_csr && csr_ready) mdrain = 1'b0;
            if (pop) void'(mq.pop_front());
            if (req_valid && e_rdy) mq.push_back('{req_instr, req_id});
            mout = mout + int'(hs) - int'(retire_vfu) - int'(retire_vlsu);
            cyc();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
